// File: rtl/xin_pkg.sv
// Shared definitions for the Xin literal store writer.
// Holds the store geometry, the literal-to-(word,bit) mapping helpers and
// the write FSM state encoding. No ports.
package xin_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int ADDR_WIDTH   = 6;
    localparam int ROM_DEPTH    = 49;
    localparam int NUM_FEATURES = 784;

    localparam int CNT_W  = $clog2(NUM_FEATURES);
    localparam int LIT_W  = $clog2(2 * NUM_FEATURES);
    localparam int WORD_W = $clog2(ROM_DEPTH);
    localparam int BIT_W  = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_FEATURES - 1);

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_WAIT   = 2'd3
    } wr_state_e;

    // Literal L lives at word L/DATA_WIDTH, bit L%DATA_WIDTH (LSB-first).
    function automatic logic [WORD_W-1:0] lit_word(input logic [LIT_W-1:0] lit);
        return WORD_W'(lit / LIT_W'(DATA_WIDTH));
    endfunction

    function automatic logic [BIT_W-1:0] lit_bit(input logic [LIT_W-1:0] lit);
        return BIT_W'(lit % LIT_W'(DATA_WIDTH));
    endfunction

endpackage

// File: rtl/xin_frame_loader_if.sv
// Bundle of the loader's stream, handshake and read-port signals.
//   s_valid/s_ready/s_bit/s_last : bit-serial feature stream
//   frame_valid/frame_release    : read-bank ownership handshake
//   addr/data                    : combinational literal word read port
//   err_len                      : frame-length error pulse
// master = producer/consumer side, slave = the loader.
interface xin_frame_loader_if;
    import xin_pkg::*;

    logic                  s_valid;
    logic                  s_ready;
    logic                  s_bit;
    logic                  s_last;
    logic                  frame_valid;
    logic                  frame_release;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  err_len;

    modport master (
        output s_valid, s_bit, s_last, frame_release, addr,
        input  s_ready, frame_valid, data, err_len
    );

    modport slave (
        input  s_valid, s_bit, s_last, frame_release, addr,
        output s_ready, frame_valid, data, err_len
    );

endinterface

// File: rtl/xin_bank.sv
// One ROM_DEPTH x DATA_WIDTH literal bank.
//   clk    : clock
//   clr_i  : zero every word this cycle (has priority over a write)
//   we_i   : write both literals of feature feat_i
//   feat_i : feature index
//   val_i  : feature value; stored as x in the lower literal half, ~x upper
//   addr_i : read address
//   data_o : read word, combinational; 0 for addresses past ROM_DEPTH
// Contents are not reset; only clr_i empties the bank.
module xin_bank
    import xin_pkg::*;
(
    input  logic                  clk,
    input  logic                  clr_i,
    input  logic                  we_i,
    input  logic [CNT_W-1:0]      feat_i,
    input  logic                  val_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] mem_q [ROM_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [ROM_DEPTH];
    logic [LIT_W-1:0]      lit_lo;
    logic [LIT_W-1:0]      lit_hi;

    assign lit_lo = LIT_W'(feat_i);
    assign lit_hi = LIT_W'(feat_i) + LIT_W'(NUM_FEATURES);

    always_comb begin
        mem_d = mem_q;
        if (clr_i) begin
            mem_d = '{default: '0};
        end else if (we_i) begin
            mem_d[lit_word(lit_lo)][lit_bit(lit_lo)] = val_i;
            mem_d[lit_word(lit_hi)][lit_bit(lit_hi)] = ~val_i;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign data_o = (addr_i < ADDR_WIDTH'(ROM_DEPTH)) ? mem_q[addr_i] : '0;

endmodule

// File: rtl/xin_frame_loader.sv
// Writer side of the Xin literal store: deserialises one frame of
// NUM_FEATURES feature bits into a ping-pong pair of literal banks while the
// consumer reads the other bank.
//   clk, rst : clock, synchronous active-high reset
//   bus      : stream in, frame_valid/frame_release, addr->data read, err_len
//
// state  | meaning
// CLEAR  | zero the write bank, restart the feature count
// LOAD   | accept one feature bit per handshake into the write bank
// COMMIT | mark the write bank FULL and swap to the other bank
// WAIT   | other bank still owned by the consumer; stall the stream
module xin_frame_loader
    import xin_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    xin_frame_loader_if.slave bus
);

    wr_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [1:0]            full_q, full_d;
    logic                  err_q, err_d;

    logic                  s_ready;
    logic                  frame_valid;
    logic                  hs;
    logic                  release_ok;
    logic                  clr;
    logic                  we;
    logic [DATA_WIDTH-1:0] rd_data [2];

    assign s_ready     = (state_q == ST_LOAD);
    assign frame_valid = full_q[rd_bank_q];
    assign hs          = bus.s_valid && s_ready;
    assign release_ok  = bus.frame_release && frame_valid;

    assign bus.s_ready     = s_ready;
    assign bus.frame_valid = frame_valid;
    assign bus.err_len     = err_q;
    assign bus.data        = frame_valid ? rd_data[rd_bank_q] : '0;

    for (genvar g = 0; g < 2; g++) begin : g_bank
        xin_bank u_bank (
            .clk    (clk),
            .clr_i  (clr && (wr_bank_q == 1'(g))),
            .we_i   (we && (wr_bank_q == 1'(g))),
            .feat_i (cnt_q),
            .val_i  (bus.s_bit),
            .addr_i (bus.addr),
            .data_o (rd_data[g])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        err_d     = 1'b0;
        clr       = 1'b0;
        we        = 1'b0;

        // Release touches only the read bank, commit only the write bank;
        // they never coincide on the same bank, so both updates stack.
        if (release_ok) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end

        unique case (state_q)
            ST_CLEAR: begin
                clr     = 1'b1;
                cnt_d   = '0;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (hs) begin
                    we = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        // Full-length frame commits even if s_last is missing.
                        err_d   = ~bus.s_last;
                        state_d = ST_COMMIT;
                    end else if (bus.s_last) begin
                        err_d   = 1'b1;
                        state_d = ST_CLEAR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                state_d           = full_d[~wr_bank_q] ? ST_WAIT : ST_CLEAR;
            end
            ST_WAIT: begin
                // Looking at the next flag value lets a release this cycle
                // restart loading one cycle earlier.
                if (!full_d[wr_bank_q]) begin
                    state_d = ST_CLEAR;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_xin_frame_loader.sv
// Directed-sequence bench with random frame contents for xin_frame_loader.
// Reference model: a queue of committed frames (front = frame the consumer
// sees); expected words are computed from the literal mapping rules.
module tb_xin_frame_loader;
    import xin_pkg::*;

    localparam int NF       = NUM_FEATURES;
    localparam int WAIT_MAX = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;

    xin_frame_loader_if bus ();

    xin_frame_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #100 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int spur    = 0;
    logic tmo   = 1'b0;
    logic last_err;
    logic [NF-1:0] q [$];
    logic [NF-1:0] fa, fb, fc, fr;
    logic [31:0] d;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [NF-1:0] rand_frame();
        logic [NF-1:0] f;
        for (int i = 0; i < NF; i++) f[i] = 1'($urandom_range(0, 1));
        return f;
    endfunction

    // Word w of the literal vector built from frame f.
    function automatic logic [31:0] exp_word(input logic [NF-1:0] f, input int w);
        logic [31:0] r;
        int lit;
        r = '0;
        if (w >= ROM_DEPTH) return '0;
        for (int b = 0; b < 32; b++) begin
            lit = w * 32 + b;
            if (lit < NF) r[b] = f[lit];
            else if (lit < 2 * NF) r[b] = ~f[lit - NF];
        end
        return r;
    endfunction

    task automatic rd(input int a, output logic [31:0] dat);
        bus.addr = ADDR_WIDTH'(a);
        #1;
        dat = bus.data;
    endtask

    task automatic send_frame(input logic [NF-1:0] f, input int n, input int last_pos);
        int guard;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            bus.s_valid = 1'b1;
            bus.s_bit   = f[i];
            bus.s_last  = (i == last_pos);
            while (!bus.s_ready && guard < WAIT_MAX && !tmo) begin
                tick();
                guard++;
            end
            if (guard >= WAIT_MAX) tmo = 1'b1;
            if (tmo) break;
            tick();
            if (i != n - 1 && bus.err_len) spur++;
            last_err = bus.err_len;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic release_frame();
        bus.frame_release = 1'b1;
        tick();
        bus.frame_release = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic check_frame(input string tag);
        int bad;
        logic [31:0] dw, e;
        bad = 0;
        chk({tag, "_fv"}, 32'(bus.frame_valid), 32'(q.size() != 0));
        for (int a = 0; a < 64; a++) begin
            rd(a, dw);
            e = (q.size() != 0) ? exp_word(q[0], a) : 32'h0;
            if (dw !== e) bad++;
        end
        chk({tag, "_words"}, 32'(bad), 32'd0);
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_bit = 1'b0;
        bus.s_last = 1'b0;
        bus.frame_release = 1'b0;
        bus.addr = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_ready", 32'(bus.s_ready), 32'd0);
        chk("rst_fv", 32'(bus.frame_valid), 32'd0);
        chk("rst_err", 32'(bus.err_len), 32'd0);
        rd(0, d);
        chk("rst_data", d, 32'h0);
        rst = 1'b0;
        tick();
        chk("load_ready", 32'(bus.s_ready), 32'd1);

        // All-zero frame and commit latency
        fa = '0;
        send_frame(fa, NF, NF - 1);
        chk("zero_err", 32'(last_err), 32'd0);
        chk("zero_fv_t1", 32'(bus.frame_valid), 32'd0);
        tick();
        q.push_back(fa);
        chk("zero_fv_t2", 32'(bus.frame_valid), 32'd1);
        rd(0, d);  chk("zero_w0", d, 32'h0000_0000);
        rd(23, d); chk("zero_w23", d, 32'h0000_0000);
        rd(24, d); chk("zero_w24", d, 32'hFFFF_0000);
        rd(25, d); chk("zero_w25", d, 32'hFFFF_FFFF);
        rd(48, d); chk("zero_w48", d, 32'hFFFF_FFFF);
        check_frame("zero");
        release_frame();
        chk("rel_fv", 32'(bus.frame_valid), 32'd0);
        release_frame();   // nothing valid: must be ignored

        // All-one frame
        fa = '1;
        send_frame(fa, NF, NF - 1);
        tick();
        q.push_back(fa);
        rd(0, d);  chk("one_w0", d, 32'hFFFF_FFFF);
        rd(24, d); chk("one_w24", d, 32'h0000_FFFF);
        rd(25, d); chk("one_w25", d, 32'h0000_0000);
        rd(49, d); chk("one_w49", d, 32'h0000_0000);
        rd(63, d); chk("one_w63", d, 32'h0000_0000);
        check_frame("one");
        release_frame();

        // Only feature 5 set
        fa = '0;
        fa[5] = 1'b1;
        send_frame(fa, NF, NF - 1);
        tick();
        q.push_back(fa);
        rd(0, d);  chk("f5_w0", d, 32'h0000_0020);
        rd(24, d); chk("f5_w24", d, 32'hFFDF_0000);
        rd(30, d); chk("f5_w30", d, 32'hFFFF_FFFF);
        check_frame("f5");
        release_frame();

        // Ping-pong without release
        fa = rand_frame();
        fb = rand_frame();
        fc = rand_frame();
        send_frame(fa, NF, NF - 1);
        tick();
        q.push_back(fa);
        send_frame(fb, NF, NF - 1);
        tick();
        q.push_back(fb);
        repeat (3) tick();
        chk("pp_stall", 32'(bus.s_ready), 32'd0);
        check_frame("pp_a");
        release_frame();
        chk("pp_rel_ready1", 32'(bus.s_ready), 32'd0);
        check_frame("pp_b");
        tick();
        chk("pp_rel_ready2", 32'(bus.s_ready), 32'd1);
        send_frame(fc, NF, NF - 1);
        chk("pp_tmo", 32'(tmo), 32'd0);
        tick();
        q.push_back(fc);
        check_frame("pp_b2");
        release_frame();
        check_frame("pp_c");
        release_frame();

        // Early s_last: discarded, then a normal frame
        fa = rand_frame();
        send_frame(fa, 100, 99);
        chk("early_err", 32'(last_err), 32'd1);
        tick();
        chk("early_err_pulse", 32'(bus.err_len), 32'd0);
        chk("early_fv", 32'(bus.frame_valid), 32'd0);
        fb = rand_frame();
        send_frame(fb, NF, NF - 1);
        tick();
        q.push_back(fb);
        check_frame("after_early");
        release_frame();

        // Missing s_last: flagged but committed
        fa = rand_frame();
        send_frame(fa, NF, -1);
        chk("nolast_err", 32'(last_err), 32'd1);
        tick();
        q.push_back(fa);
        check_frame("nolast");
        release_frame();

        // Reset in the middle of a frame, with a frame already visible
        fa = rand_frame();
        send_frame(fa, NF, NF - 1);
        tick();
        q.push_back(fa);
        check_frame("pre_rst");
        fr = rand_frame();
        send_frame(fr, 300, -1);
        rst = 1'b1;
        tick();
        q.delete();
        chk("mid_rst_fv", 32'(bus.frame_valid), 32'd0);
        chk("mid_rst_ready", 32'(bus.s_ready), 32'd0);
        rd(0, d);
        chk("mid_rst_data", d, 32'h0);
        rst = 1'b0;
        tick();
        chk("mid_rst_load", 32'(bus.s_ready), 32'd1);

        // Release and commit in the same cycle
        fa = rand_frame();
        fb = rand_frame();
        send_frame(fa, NF, NF - 1);
        tick();
        q.push_back(fa);
        send_frame(fb, NF, NF - 1);
        chk("sim_fv_before", 32'(bus.frame_valid), 32'd1);
        bus.frame_release = 1'b1;
        tick();
        bus.frame_release = 1'b0;
        void'(q.pop_front());
        q.push_back(fb);
        check_frame("sim");

        chk("ready_timeout", 32'(tmo), 32'd0);
        chk("err_spurious", 32'(spur), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/xin_frame_loader.md
Name: xin_frame_loader

Overview:
Writer side of the Xin literal store. It accepts a bit-serial stream of binarized features, one frame of NUM_FEATURES bits per frame. It builds the literal vector for each frame: x in the lower half, ~x in the upper half. That vector is stored in a ping-pong pair of ROM_DEPTH x DATA_WIDTH banks. The clause-evaluation datapath reads one bank through the same addr->data combinational port as ROM_XIN while the next frame loads into the other bank.

Parameters:
DATA_WIDTH, 32, literal word width
ADDR_WIDTH, 6, read address width
ROM_DEPTH, 49, words per bank; 2*NUM_FEATURES <= DATA_WIDTH*ROM_DEPTH required
NUM_FEATURES, 784, feature bits per frame

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
s_valid  in  1  feature bit valid
s_ready  out  1  loader accepts a bit this cycle
s_bit  in  1  binarized feature value
s_last  in  1  marks the final bit of a frame
frame_valid  out  1  read bank holds a complete frame
frame_release  in  1  consumer finished with the read bank
addr  in  ADDR_WIDTH  literal word address
data  out  DATA_WIDTH  literal word, combinational
err_len  out  1  one-cycle pulse on frame-length error

Behaviour:
- Literal mapping, LSB-first:
  - Literal L lives at word L/DATA_WIDTH, bit L%DATA_WIDTH.
  - Feature i gives literal i = s_bit and literal NUM_FEATURES+i = ~s_bit.
  - Bits above 2*NUM_FEATURES-1 read 0.
- Reset: state CLEAR, wr_bank=0, rd_bank=0, both banks EMPTY, frame_valid=0, s_ready=0, err_len=0, cnt=0.
- Bank contents are not reset; they are cleared only by the CLEAR state.
- Write FSM:
  - CLEAR: zero all words of wr_bank in one cycle, cnt=0, go to LOAD.
  - LOAD: s_ready=1. On a handshake (s_valid&&s_ready), write both literals of feature cnt into wr_bank and advance cnt.
    - Handshake with cnt==NUM_FEATURES-1: go to COMMIT. If s_last=0 on that beat, pulse err_len; the frame is still committed.
    - Handshake with s_last=1 and cnt<NUM_FEATURES-1: pulse err_len, discard the frame, go to CLEAR on the same bank.
  - COMMIT: mark wr_bank FULL and toggle wr_bank. If the new wr_bank is FULL, go to WAIT; otherwise go to CLEAR.
  - WAIT: s_ready=0. When the new wr_bank becomes EMPTY, go to CLEAR.
- Read side:
  - frame_valid=1 iff bank rd_bank is FULL.
  - data = mem[rd_bank][addr] when frame_valid=1 and addr<ROM_DEPTH; otherwise data=0. Zero latency.
- Release:
  - frame_release with frame_valid=1: rd_bank becomes EMPTY and rd_bank toggles.
  - frame_valid next cycle reflects the other bank's FULL flag.
  - frame_release with frame_valid=0 is ignored.
- Simultaneous COMMIT and release in one cycle: both flag updates apply. The committing bank cannot be the released bank.
- Latency: last bit accepted in cycle T, COMMIT in T+1. frame_valid rises in T+2 if rd_bank pointed to the committed bank and it was EMPTY.
- Throughput: 1 bit/cycle in LOAD; 2 cycles of overhead per frame (COMMIT, CLEAR).
- Reset mid-load: the partial frame is lost; all reset values apply in the next cycle.
- Widths: cnt is $clog2(NUM_FEATURES) bits and never wraps past NUM_FEATURES-1.

Decomposition:
- Shared package xin_pkg holds:
  - NUM_FEATURES, DATA_WIDTH, ROM_DEPTH, ADDR_WIDTH.
  - Functions lit_word(L) and lit_bit(L).
  - Enum for write FSM states CLEAR/LOAD/COMMIT/WAIT.
- One sub-module xin_bank, instantiated twice. It provides a ROM_DEPTH x DATA_WIDTH register array with a one-cycle clear, a single-feature dual-literal write port (feature index, value, enable), and a combinational read port.

Test Plan:
- All-zero frame, 784 beats, s_last on beat 784 -> words 0..23=0x00000000, word 24=0xFFFF0000, words 25..48=0xFFFFFFFF; frame_valid rises 2 cycles after the last beat.
- All-one frame -> words 0..23=0xFFFFFFFF, word 24=0x0000FFFF, words 25..48=0x00000000; addr 49..63 -> 0.
- Only feature 5 set -> word 0=0x00000020, word 24=0xFFDF0000, words 25..48=0xFFFFFFFF.
- Ping-pong without release:
  - Two frames commit; the third frame sees s_ready=0 (WAIT) and reads still return frame 1.
  - frame_release -> data switches to frame 2 the next cycle; s_ready returns 2 cycles after release.
- s_last asserted on beat 100 -> one-cycle err_len, frame_valid stays 0; a following correct frame loads normally. Missing s_last on beat 784 -> err_len pulse and the frame still commits.
- rst asserted mid-frame at beat 300 -> next cycle frame_valid=0, s_ready=0, data=0, then CLEAR->LOAD. Release and commit in the same cycle -> frame_valid stays 1 and data shows the newly committed frame.
